// File: rtl/corner_packer.sv
// Packs 32-bit corner records four to a 128-bit word, queues words in a FIFO
// and closes every frame with a PAD-filled partial word and a counter trailer.
module corner_packer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] PAD        = 32'hFFFF_FFFF
) (
  input  logic         c,
  input  logic         rst,
  input  logic [31:0]  d,
  input  logic         dv,
  input  logic         fv,
  output logic [127:0] q,
  output logic         q_valid,
  input  logic         q_ready,
  output logic [15:0]  rec_cnt,
  output logic [15:0]  drop_cnt,
  output logic         busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACTIVE  = 2'd1;
  localparam logic [1:0] S_FLUSH   = 2'd2;
  localparam logic [1:0] S_TRAILER = 2'd3;

  logic [1:0]   state_q, state_d;
  logic         fv_d1_q;
  logic         pend_q, pend_d;
  logic [1:0]   idx_q, idx_d;
  logic [127:0] word_q, word_d;
  logic         stg_vld_q, stg_vld_d;
  logic [127:0] stg_q, stg_d;
  logic [15:0]  rec_cnt_q, rec_cnt_d;
  logic [15:0]  drop_cnt_q, drop_cnt_d;
  logic [15:0]  fnum_q, fnum_d;
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [127:0] mem_q [FIFO_DEPTH];

  logic         fv_rise, fv_fall;
  logic         full, empty, push, pop;
  logic [127:0] wdata, lane_word, partial, trailer;

  assign fv_rise = fv & ~fv_d1_q;
  assign fv_fall = ~fv & fv_d1_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = ~empty & q_ready;

  assign q_valid  = ~empty;
  assign q        = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign rec_cnt  = rec_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != S_IDLE) || ~empty;

  assign trailer = {PAD, 16'h0, fnum_q, 16'h0, rec_cnt_q, 16'h0, drop_cnt_q};

  always_comb begin
    lane_word = word_q;
    lane_word[{idx_q, 5'd0} +: 32] = d;
    partial = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      partial[32*k +: 32] = (k < 32'(idx_q)) ? word_q[32*k +: 32] : PAD;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    idx_d      = idx_q;
    word_d     = word_q;
    stg_vld_d  = 1'b0;
    stg_d      = stg_q;
    rec_cnt_d  = rec_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fnum_d     = fnum_q;
    push       = 1'b0;
    wdata      = stg_q;

    // A completed data word owns the write port the cycle after it forms;
    // full is judged on the registered pointers, so a same-cycle pop cannot save it.
    if (stg_vld_q) begin
      if (!full) begin
        push = 1'b1;
      end else begin
        drop_cnt_d = (drop_cnt_q > 16'hFFFB) ? 16'hFFFF : drop_cnt_q + 16'd4;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (fv_rise || pend_q) begin
          state_d    = S_ACTIVE;
          pend_d     = 1'b0;
          idx_d      = 2'd0;
          rec_cnt_d  = '0;
          drop_cnt_d = '0;
        end
      end
      S_ACTIVE: begin
        if (dv) begin
          word_d = lane_word;
          idx_d  = idx_q + 2'd1;
          if (rec_cnt_q != 16'hFFFF) rec_cnt_d = rec_cnt_q + 16'd1;
          if (idx_q == 2'd3) begin
            stg_vld_d = 1'b1;
            stg_d     = lane_word;
          end
        end
        if (fv_fall) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (fv_rise) pend_d = 1'b1;
        if (idx_q == 2'd0) begin
          state_d = S_TRAILER;
        end else if (!full && !stg_vld_q) begin
          push    = 1'b1;
          wdata   = partial;
          idx_d   = 2'd0;
          state_d = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (fv_rise) pend_d = 1'b1;
        if (!full && !stg_vld_q) begin
          push    = 1'b1;
          wdata   = trailer;
          fnum_d  = fnum_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge c) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fv_d1_q    <= 1'b1;
      pend_q     <= 1'b0;
      idx_q      <= 2'd0;
      word_q     <= '0;
      stg_vld_q  <= 1'b0;
      stg_q      <= '0;
      rec_cnt_q  <= '0;
      drop_cnt_q <= '0;
      fnum_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fv_d1_q    <= fv;
      pend_q     <= pend_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      stg_vld_q  <= stg_vld_d;
      stg_q      <= stg_d;
      rec_cnt_q  <= rec_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fnum_q     <= fnum_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge c) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: tb/tb_corner_packer.sv
// Bench for corner_packer: frame-level reference model of expected words,
// table-driven frames, hand sequences for corners, then random frames.
module tb_corner_packer;

  localparam logic [31:0] PAD = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  d = '0;
  logic         dv = 1'b0;
  logic         fv = 1'b1;
  logic [127:0] q;
  logic         q_valid;
  logic         q_ready = 1'b1;
  logic [15:0]  rec_cnt, drop_cnt;
  logic         busy;

  corner_packer #(.FIFO_DEPTH(8), .PAD(PAD)) dut (
    .c(clk), .rst(rst), .d(d), .dv(dv), .fv(fv),
    .q(q), .q_valid(q_valid), .q_ready(q_ready),
    .rec_cnt(rec_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_words = 0;
  bit rand_ready = 1'b0;
  logic [127:0] exp_q[$];
  logic [15:0] mdl_fnum = '0;

  typedef struct {
    int nrec;
    bit dense;
    bit fall_last;
    int exp_words;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) q_ready = ($urandom_range(0, 3) != 0);
  endtask

  always @(negedge clk) begin
    if (!rst && q_valid && q_ready) begin
      n_words++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_word: got %h expected no word", q);
      end else begin
        check("word", q, exp_q.pop_front());
      end
    end
  end

  function automatic logic [127:0] trailer_word(input logic [15:0] fn, input int nrec, input int ndrop);
    return {PAD, 16'h0, fn, 16'h0, 16'(nrec), 16'h0, 16'(ndrop)};
  endfunction

  task automatic run_frame(input int n, input bit dense, input bit fall_last,
                           input int lead, input int low, input bit chk_lat);
    logic [31:0] recs[$];
    logic [127:0] w;
    int rem;
    fv = 1'b1;
    repeat (lead) step();
    for (int i = 0; i < n; i++) begin
      if (!dense) repeat ($urandom_range(0, 2)) step();
      d  = $urandom & 32'h9FFF_FFFF;
      dv = 1'b1;
      recs.push_back(d);
      if (recs.size() % 4 == 0)
        exp_q.push_back({recs[i], recs[i-1], recs[i-2], recs[i-3]});
      if (fall_last && i == n - 1) fv = 1'b0;
      step();
      dv = 1'b0;
      if (chk_lat && i == 3) begin
        check("lat_q_valid_low", q_valid, 1'b0);
        step();
        check("lat_q_valid_high", q_valid, 1'b1);
      end
    end
    fv  = 1'b0;
    rem = n % 4;
    if (rem != 0) begin
      w = '0;
      for (int k = 0; k < 4; k++) w[32*k +: 32] = (k < rem) ? recs[n-rem+k] : PAD;
      exp_q.push_back(w);
    end
    exp_q.push_back(trailer_word(mdl_fnum, n, 0));
    mdl_fnum++;
    repeat (low) step();
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && (busy || exp_q.size() != 0); k++) step();
    check("drain_done", {busy, exp_q.size() == 0}, 2'b01);
    repeat (2) step();
  endtask

  initial begin
    int w0;
    tbl[0] = '{nrec: 8,  dense: 1, fall_last: 0, exp_words: 3};
    tbl[1] = '{nrec: 5,  dense: 1, fall_last: 0, exp_words: 3};
    tbl[2] = '{nrec: 4,  dense: 1, fall_last: 1, exp_words: 2};
    tbl[3] = '{nrec: 1,  dense: 0, fall_last: 0, exp_words: 2};
    tbl[4] = '{nrec: 0,  dense: 1, fall_last: 0, exp_words: 1};
    tbl[5] = '{nrec: 3,  dense: 0, fall_last: 1, exp_words: 2};
    tbl[6] = '{nrec: 12, dense: 0, fall_last: 0, exp_words: 4};

    // Reset state, with fv already high at release
    repeat (3) step();
    check("rst_q_valid", q_valid, 1'b0);
    check("rst_q", q, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_rec_cnt", rec_cnt, 16'h0);
    check("rst_drop_cnt", drop_cnt, 16'h0);
    rst = 1'b0;
    repeat (5) step();
    check("fv_high_at_release_busy", busy, 1'b0);
    fv = 1'b0;
    repeat (2) step();

    // Eight records, latency of the first word
    run_frame(8, 1, 0, 1, 1, 1);
    drain();
    check("f8_rec_cnt", rec_cnt, 16'd8);
    check("f8_drop_cnt", drop_cnt, 16'd0);

    // Table of frame shapes
    for (int t = 0; t < 7; t++) begin
      w0 = n_words;
      run_frame(tbl[t].nrec, tbl[t].dense, tbl[t].fall_last, 1, 1, 0);
      drain();
      check($sformatf("tbl%0d_words", t), n_words - w0, tbl[t].exp_words);
      check($sformatf("tbl%0d_rec_cnt", t), rec_cnt, 16'(tbl[t].nrec));
      check($sformatf("tbl%0d_drop_cnt", t), drop_cnt, 16'd0);
    end

    // New frame rises while the previous flush/trailer is still pending
    run_frame(5, 1, 0, 1, 1, 0);
    fv = 1'b1;
    repeat (6) step();
    check("pend_rec_cnt_cleared", rec_cnt, 16'd0);
    check("pend_busy", busy, 1'b1);
    run_frame(6, 1, 0, 0, 1, 0);
    drain();
    check("pend_rec_cnt", rec_cnt, 16'd6);

    // Consumer stalled: FIFO fills, later words are dropped, trailer waits
    q_ready = 1'b0;
    w0 = n_words;
    begin
      logic [31:0] recs[$];
      fv = 1'b1;
      step();
      for (int i = 0; i < 40; i++) begin
        d  = $urandom & 32'h9FFF_FFFF;
        dv = 1'b1;
        recs.push_back(d);
        if (i % 4 == 3 && i < 32)
          exp_q.push_back({recs[i], recs[i-1], recs[i-2], recs[i-3]});
        step();
      end
      dv = 1'b0;
      fv = 1'b0;
      exp_q.push_back(trailer_word(mdl_fnum, 40, 8));
      mdl_fnum++;
    end
    repeat (20) step();
    check("stall_q_valid", q_valid, 1'b1);
    check("stall_busy", busy, 1'b1);
    check("stall_drop_cnt", drop_cnt, 16'd8);
    check("stall_rec_cnt", rec_cnt, 16'd40);
    check("stall_q_hold_a", q, exp_q[0]);
    repeat (3) step();
    check("stall_q_hold_b", q, exp_q[0]);
    check("stall_no_pop", n_words - w0, 0);
    q_ready = 1'b1;
    drain();
    check("stall_words", n_words - w0, 9);
    check("stall_hold_rec_cnt", rec_cnt, 16'd40);
    check("stall_hold_drop_cnt", drop_cnt, 16'd8);

    // Reset in mid-frame with fv still high
    fv = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      d  = $urandom & 32'h9FFF_FFFF;
      dv = 1'b1;
      step();
    end
    dv  = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mdl_fnum = '0;
    w0 = n_words;
    repeat (5) step();
    check("midrst_q_valid", q_valid, 1'b0);
    check("midrst_q", q, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rec_cnt", rec_cnt, 16'd0);
    repeat (5) step();
    check("midrst_no_restart", busy, 1'b0);
    check("midrst_no_words", n_words - w0, 0);
    fv = 1'b0;
    repeat (2) step();
    run_frame(4, 1, 0, 1, 1, 0);
    drain();
    check("after_rst_rec_cnt", rec_cnt, 16'd4);

    // Random frames with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(0, 17);
      run_frame(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, $urandom_range(1, 3), 0);
      drain();
      check($sformatf("rnd%0d_rec_cnt", f), rec_cnt, 16'(n));
      check($sformatf("rnd%0d_drop_cnt", f), drop_cnt, 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/corner_packer.md
CORNER_PACKER -- requirements
Module: corner_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: output word FIFO depth in 128-bit words; power of 2, minimum 4.
REQ-002 Parameter PAD, default 32'hFFFF_FFFF: filler for unused lanes of a partial word (bits 30:29 set, so never a legal corner record).
REQ-003 c  input  1  pixel clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 d  input  32  corner record {cam, 2'b00, col[10:0], row[9:0], score[7:0]}.
REQ-006 dv  input  1  record strobe; d is valid in that cycle.
REQ-007 fv  input  1  frame valid, same timing as the upstream detector.
REQ-008 q  output  128  packed word; lane k occupies bits 32k+31:32k.
REQ-009 q_valid  output  1  q holds a word.
REQ-010 q_ready  input  1  consumer accepts q; a pop happens when q_valid and q_ready are both high.
REQ-011 rec_cnt  output  16  records accepted in the current or last frame, saturating.
REQ-012 drop_cnt  output  16  records lost to FIFO overflow in the current or last frame, saturating.
REQ-013 busy  output  1  high when the state is not IDLE or the FIFO is non-empty.

Function
REQ-014 The FSM states shall be IDLE, ACTIVE, FLUSH and TRAILER.
REQ-015 IDLE to ACTIVE shall occur on an fv rising edge (fv & ~fv_d1) or when pend is set; pend and the lane index clear, and rec_cnt and drop_cnt clear to 0 on that edge.
REQ-016 In ACTIVE, each dv shall write d into the lane given by idx (first record in lane 0), then idx increments mod 4 and rec_cnt increments.
REQ-017 A word shall be complete on the edge that writes lane 3; the FIFO write happens on the next edge.
REQ-018 With the FIFO empty, q_valid shall be high in the cycle after that FIFO-write edge, i.e. 2 cycles after the 4th record is sampled.
REQ-019 FIFO-full shall be evaluated before any pop in the same cycle, so a data word presented while full is blocked even if a pop occurs.
REQ-020 A blocked data word shall be discarded: drop_cnt increases by its record count, saturating at 16'hFFFF; idx restarts at 0.
REQ-021 dv and an fv falling edge in the same cycle: the record shall be accepted, then the FSM enters FLUSH.
REQ-022 FLUSH, idx != 0: a partial word shall be written with lanes idx..3 set to PAD; FLUSH holds until the FIFO is not full, and this word is never dropped.
REQ-023 FLUSH, idx == 0: no word is written; the FSM goes to TRAILER on the next edge.
REQ-024 TRAILER shall write the word {PAD, 16'h0 + frame_num, 16'h0 + rec_cnt, 16'h0 + drop_cnt} (lane3..lane0), waiting while the FIFO is full, then go to IDLE; frame_num increments, wrapping at 16'hFFFF to 0.
REQ-025 dv outside ACTIVE shall be ignored and not counted.
REQ-026 An fv rising edge seen in FLUSH or TRAILER shall set pend, so the new frame starts on the first IDLE cycle.
REQ-027 While q_valid & ~q_ready, q shall hold stable; words shall leave in write order.
REQ-028 rec_cnt and drop_cnt shall hold their final values from the trailer until the next frame start.

Reset
REQ-029 rst high shall force: state IDLE, FIFO empty, q_valid 0, q 128'h0, idx 0, rec_cnt 0, drop_cnt 0, frame_num 0, pend 0, busy 0.
REQ-030 fv_d1 shall reset to 1, so fv already high at reset release does not start a frame mid-frame.
REQ-031 Reset mid-frame shall discard all buffered records and words; no trailer is emitted.

Verification
REQ-032 fv rise, 8 dv records R0..R7, fv fall, q_ready=1 -> words {R3,R2,R1,R0}, {R7,R6,R5,R4}, then trailer {FFFFFFFF, 0, 8, 0}; first q_valid 2 cycles after R3 is sampled.
REQ-033 Frame of 5 records -> 2nd word {PAD, PAD, PAD, R4}; trailer rec_cnt=5; frame_num increments to 1 for the next frame.
REQ-034 q_ready=0 with FIFO_DEPTH=8, 40 records -> 8 words kept; drop_cnt=8; trailer waits until q_ready=1, then reports rec_cnt=40, drop_cnt=8.
REQ-035 Trailer pending while fv rises again -> trailer emitted first, then the new frame starts (pend path) with counters cleared.
REQ-036 rst pulsed after 3 records with fv still high -> no output, q_valid=0, busy=0; nothing restarts until fv falls and rises again.
REQ-037 dv and fv falling in the same cycle as the 4th record -> full word emitted, no PAD word, then the trailer.
